dequantizer_stream: RTL and testbench
=====================================

Name: dequantizer_stream

Overview:
- Inverse of the shift-based quantizer: restores quantized DCT coefficients before the IDCT on the decode path.
- Receives a raster-order coefficient stream, one coefficient per beat, for each BLOCK_SIZE x BLOCK_SIZE block.
- Left-shifts each coefficient by its per-position shift value, saturates the result, and emits it with row/col tags and an end-of-block marker.
- The shift table is runtime-writable and uses the same 3-bit shift encoding as the quantization table.

Parameters:
- BLOCK_SIZE, 8, block edge length; positions per block N = BLOCK_SIZE*BLOCK_SIZE.
- COEFF_WIDTH, 52, signed width of the input coefficients.
- OUT_WIDTH, 52, signed width of the dequantized output (must be >= COEFF_WIDTH).
- SHIFT_WIDTH, 3, width of each shift table entry.

Ports:
- clk, input, 1, the single clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, input coefficient valid.
- in_ready, output, 1, block can accept a coefficient.
- in_coeff, input, COEFF_WIDTH, signed quantized coefficient.
- in_last, input, 1, upstream marks the final coefficient of a block.
- out_valid, output, 1, output coefficient valid.
- out_ready, input, 1, downstream accepts the output.
- out_coeff, output, OUT_WIDTH, signed dequantized coefficient.
- out_row, output, clog2(BLOCK_SIZE), row of out_coeff.
- out_col, output, clog2(BLOCK_SIZE), column of out_coeff.
- out_last, output, 1, output is position N-1 or an early in_last terminator.
- tbl_we, input, 1, shift table write enable.
- tbl_addr, input, clog2(N), table index (row*BLOCK_SIZE+col).
- tbl_data, input, SHIFT_WIDTH, shift value to write.
- framing_err, output, 1, one-cycle pulse on an in_last/position mismatch.

Behaviour:
- Reset (async assert, sync deassert):
  - out_valid=0, out_coeff=0, out_row=0, out_col=0, out_last=0, framing_err=0.
  - Position counter pos=0.
  - All table entries=0 (identity shift).
- Handshake:
  - An input transfers when in_valid && in_ready.
  - An output transfers when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (single registered output stage, no combinational path from in_valid to out_valid).
- Latency: exactly 1 cycle; a coefficient accepted at edge k is presented on out_* after edge k.
- Output hold: while out_valid=1 and out_ready=0, all out_* hold stable.
- Arithmetic: out_coeff = sign_extend(in_coeff, OUT_WIDTH) <<< table[pos].
- Saturation:
  - If the shifted value leaves the signed OUT_WIDTH range, clamp to 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1).
  - Zero input always yields 0.
- Tagging: out_row = pos / BLOCK_SIZE and out_col = pos % BLOCK_SIZE of the accepted input.
- Position counter:
  - Increments on each input transfer.
  - Wraps N-1 -> 0.
  - out_last=1 for the beat taken at pos=N-1.
- Framing:
  - in_last=1 at pos != N-1: out_last=1 on that beat, framing_err pulses the cycle after the transfer, and pos resets to 0.
  - in_last=0 at pos=N-1: out_last=1, framing_err pulses, and pos wraps to 0 as normal.
  - Matched in_last: no error.
- Table writes:
  - Allowed at any time, 1-cycle write.
  - A write and a transfer to the same index in the same cycle: the transfer uses the old value; the new value applies from the next block.
- Simultaneous input and output transfers in one cycle sustain 1 coefficient/cycle throughput.
- Reset mid-block: pending output is dropped, pos returns to 0, and the table clears.

Test Plan:
- Identity: after reset with no table writes, stream 64 coefficients in_coeff=pos-32 -> out_coeff equals input; out_row/out_col walk 0..7 in raster order; out_last only on beat 63; latency 1.
- Shift/sign: table[0]=3, table[9]=2; inputs -5 at pos0 and 7 at pos9 -> out_coeff=-40 and 28; out_row=1, out_col=1 for pos9.
- Saturation: OUT_WIDTH=COEFF_WIDTH=52, table[5]=7, in_coeff=2^50 at pos5 -> out_coeff=2^51-1; in_coeff=-2^50 -> out_coeff=-2^51.
- Backpressure: hold out_ready=0 for 5 cycles mid-block -> in_ready=0 after the first beat, out_* stable, no loss or duplication; full-rate streaming with out_ready=1 gives 1 output/cycle.
- Framing: in_last at pos 10 -> out_last on that beat, framing_err pulse, next coefficient tagged row0/col0; second block with no in_last at pos 63 -> framing_err pulse.
- Write collision and reset: write table[4]=1 in the same cycle pos4 is accepted with in_coeff=3 -> out_coeff=3, and the next block's pos4 yields 6; assert rst mid-block -> out_valid drops immediately, and the next block starts at pos 0 with the identity table.

Source files
------------

// File: rtl/dequantizer_stream.sv
// Streaming dequantizer: left-shifts raster-order DCT coefficients by a per-position
// shift table, saturates to OUT_WIDTH and tags each beat with row/col/last.
module dequantizer_stream #(
    parameter int BLOCK_SIZE  = 8,
    parameter int COEFF_WIDTH = 52,
    parameter int OUT_WIDTH   = 52,
    parameter int SHIFT_WIDTH = 3,
    localparam int N          = BLOCK_SIZE * BLOCK_SIZE,
    localparam int RC_W       = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1,
    localparam int POS_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [COEFF_WIDTH-1:0] in_coeff,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_coeff,
    output logic [RC_W-1:0]               out_row,
    output logic [RC_W-1:0]               out_col,
    output logic                          out_last,
    input  logic                          tbl_we,
    input  logic [POS_W-1:0]              tbl_addr,
    input  logic [SHIFT_WIDTH-1:0]        tbl_data,
    output logic                          framing_err
);

    localparam int MAX_SHIFT = (1 << SHIFT_WIDTH) - 1;
    localparam int WIDE_W    = OUT_WIDTH + MAX_SHIFT;
    localparam int HEAD_W    = WIDE_W - OUT_WIDTH + 1;

    localparam logic [POS_W-1:0]     LAST_POS = POS_W'(N - 1);
    localparam logic [RC_W-1:0]      LAST_COL = RC_W'(BLOCK_SIZE - 1);
    localparam logic [OUT_WIDTH-1:0] SAT_MAX  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_MIN  = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Shift table
    logic [SHIFT_WIDTH-1:0] tbl_q [N];
    logic [N-1:0]           tbl_hit;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_tbl_hit
            assign tbl_hit[gi] = tbl_we && (tbl_addr == POS_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (tbl_hit[i]) begin
                    tbl_q[i] <= tbl_data;
                end
            end
        end
    end

    // Position tracking and output stage
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [RC_W-1:0]      row_q, row_d;
    logic [RC_W-1:0]      col_q, col_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_coeff_q, out_coeff_d;
    logic [RC_W-1:0]      out_row_q, out_row_d;
    logic [RC_W-1:0]      out_col_q, out_col_d;
    logic                 out_last_q, out_last_d;
    logic                 framing_err_q, framing_err_d;

    logic                   in_fire;
    logic                   at_last;
    logic                   block_end;
    logic [SHIFT_WIDTH-1:0] shamt;
    logic [WIDE_W-1:0]      wide_ext;
    logic [WIDE_W-1:0]      wide_shl;
    logic [HEAD_W-1:0]      head;
    logic [OUT_WIDTH-1:0]   sat_coeff;

    assign in_ready  = !out_valid_q || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign at_last   = (pos_q == LAST_POS);
    assign block_end = at_last || in_last;

    // The table read sees the pre-write value, so a same-cycle write only affects later beats.
    assign shamt = tbl_q[pos_q];

    // Shift in a width that cannot lose bits, then clamp if anything above the
    // OUT_WIDTH sign bit disagrees with it.
    always_comb begin
        wide_ext = {{(WIDE_W-COEFF_WIDTH){in_coeff[COEFF_WIDTH-1]}}, in_coeff};
        wide_shl = wide_ext << shamt;
        head     = wide_shl[WIDE_W-1:OUT_WIDTH-1];
        if ((head == '0) || (head == '1)) begin
            sat_coeff = wide_shl[OUT_WIDTH-1:0];
        end else if (in_coeff[COEFF_WIDTH-1]) begin
            sat_coeff = SAT_MIN;
        end else begin
            sat_coeff = SAT_MAX;
        end
    end

    always_comb begin
        pos_d         = pos_q;
        row_d         = row_q;
        col_d         = col_q;
        out_valid_d   = out_valid_q;
        out_coeff_d   = out_coeff_q;
        out_row_d     = out_row_q;
        out_col_d     = out_col_q;
        out_last_d    = out_last_q;
        framing_err_d = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            out_valid_d   = 1'b1;
            out_coeff_d   = sat_coeff;
            out_row_d     = row_q;
            out_col_d     = col_q;
            out_last_d    = block_end;
            framing_err_d = (in_last != at_last);

            if (block_end) begin
                pos_d = '0;
                row_d = '0;
                col_d = '0;
            end else begin
                pos_d = pos_q + 1'b1;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q         <= '0;
            row_q         <= '0;
            col_q         <= '0;
            out_valid_q   <= 1'b0;
            out_coeff_q   <= '0;
            out_row_q     <= '0;
            out_col_q     <= '0;
            out_last_q    <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            pos_q         <= pos_d;
            row_q         <= row_d;
            col_q         <= col_d;
            out_valid_q   <= out_valid_d;
            out_coeff_q   <= out_coeff_d;
            out_row_q     <= out_row_d;
            out_col_q     <= out_col_d;
            out_last_q    <= out_last_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_coeff   = out_coeff_q;
    assign out_row     = out_row_q;
    assign out_col     = out_col_q;
    assign out_last    = out_last_q;
    assign framing_err = framing_err_q;

endmodule

// File: tb/tb_dequantizer_stream.sv
// Scoreboard bench for dequantizer_stream: the driver queues expected beats,
// an independent monitor checks each presented output against the queue head.
module tb_dequantizer_stream;

    localparam logic signed [51:0] P50     = 52'h4_0000_0000_0000;
    localparam logic signed [51:0] NEG_P50 = 52'hC_0000_0000_0000;
    localparam logic signed [51:0] SMAX    = 52'h7_FFFF_FFFF_FFFF;
    localparam logic signed [51:0] SMIN    = 52'h8_0000_0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, in_last;
    logic signed [51:0] in_coeff;
    logic               out_valid, out_ready, out_last;
    logic signed [51:0] out_coeff;
    logic [2:0]         out_row, out_col;
    logic               tbl_we;
    logic [5:0]         tbl_addr;
    logic [2:0]         tbl_data;
    logic               framing_err;

    dequantizer_stream dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [51:0] coeff;
        logic [2:0]         row;
        logic [2:0]         col;
        logic               last;
        logic               err;
        int                 acc;
    } sb_t;

    sb_t q[$];
    int  total = 0;
    int  bad = 0;
    int  cycle_cnt = 0;
    int  m_pos = 0;
    int  tbl_m [64];
    bit  held;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [51:0] dq(input longint c, input int s);
        longint v;
        longint maxv;
        longint minv;
        maxv = (64'sd1 <<< 51) - 1;
        minv = -(64'sd1 <<< 51);
        v = c <<< s;
        if (v > maxv) v = maxv;
        if (v < minv) v = minv;
        return v[51:0];
    endfunction

    task automatic send_beat_w(input logic signed [51:0] c, input logic lst,
                               input logic signed [51:0] exp, input logic we,
                               input logic [5:0] addr, input logic [2:0] data);
        sb_t it;
        int  n;
        in_valid = 1'b1; in_coeff = c; in_last = lst;
        tbl_we = we; tbl_addr = addr; tbl_data = data;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL in_ready_timeout: got 0 want 1 (t=%0t)", $time);
        end else begin
            it.coeff = exp;
            it.row   = 3'(m_pos / 8);
            it.col   = 3'(m_pos % 8);
            it.last  = lst || (m_pos == 63);
            it.err   = lst != (m_pos == 63);
            it.acc   = cycle_cnt;
            q.push_back(it);
            $display("beat pos=%0d in=%0d last=%0b exp=%0d", m_pos, c, lst, exp);
            m_pos = (lst || m_pos == 63) ? 0 : m_pos + 1;
            if (we) tbl_m[addr] = int'(data);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; in_last = 1'b0; tbl_we = 1'b0;
    endtask

    task automatic send_beat(input logic signed [51:0] c, input logic lst, input logic signed [51:0] exp);
        send_beat_w(c, lst, exp, 1'b0, 6'd0, 3'd0);
    endtask

    task automatic fill_until(input int p);
        int c;
        for (int i = m_pos; i < p; i++) begin
            c = i * 7 - 100;
            send_beat(52'(c), 1'b0, dq(longint'(c), tbl_m[i]));
        end
    endtask

    task automatic fill_block();
        int c;
        for (int i = m_pos; i < 64; i++) begin
            c = i * 7 - 100;
            send_beat(52'(c), i == 63, dq(longint'(c), tbl_m[i]));
        end
    endtask

    task automatic tbl_write(input int addr, input int data);
        tbl_we = 1'b1; tbl_addr = 6'(addr); tbl_data = 3'(data);
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        tbl_m[addr] = data;
        $display("table[%0d]=%0d", addr, data);
    endtask

    // Monitor: first presentation checks everything incl. latency/error pulse,
    // held cycles check the beat stays stable with no repeated error pulse.
    initial begin
        sb_t it;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output: got coeff=%0d want none", out_coeff);
                end else begin
                    it = q[0];
                    chk("out_coeff", out_coeff, it.coeff);
                    chk("out_row", out_row, it.row);
                    chk("out_col", out_col, it.col);
                    chk("out_last", out_last, it.last);
                    if (!held) begin
                        chk("framing_err", framing_err, it.err);
                        chk("latency", cycle_cnt, it.acc + 1);
                    end else begin
                        chk("framing_err_hold", framing_err, 0);
                    end
                    if (out_ready) void'(q.pop_front());
                end
                held = !out_ready;
            end else begin
                chk("framing_err_idle", framing_err, 0);
            end
        end
    end

    initial begin
        int c0;
        int n;
        for (int i = 0; i < 64; i++) tbl_m[i] = 0;
        rst = 1'b1; in_valid = 1'b0; in_coeff = '0; in_last = 1'b0;
        out_ready = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_coeff", out_coeff, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_framing_err", framing_err, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Identity table, full-rate streaming
        c0 = cycle_cnt;
        for (int i = 0; i < 64; i++) send_beat(52'(i - 32), i == 63, 52'(i - 32));
        chk("full_rate_cycles", cycle_cnt - c0, 64);

        // Shift and sign
        tbl_write(0, 3);
        tbl_write(9, 2);
        send_beat(-52'sd5, 1'b0, -52'sd40);
        fill_until(9);
        send_beat(52'sd7, 1'b0, 52'sd28);
        fill_block();

        // Saturation in both directions
        tbl_write(5, 7);
        fill_until(5);
        send_beat(P50, 1'b0, SMAX);
        fill_block();
        fill_until(5);
        send_beat(NEG_P50, 1'b0, SMIN);
        send_beat(52'sd0, 1'b0, 52'sd0);
        fill_block();

        // Backpressure mid-block
        fork
            begin
                fill_until(20);
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        fill_block();

        // Early in_last, then a block missing its in_last
        fill_until(10);
        send_beat(52'sd33, 1'b1, dq(33, tbl_m[10]));
        fill_block();
        for (int i = 0; i < 64; i++) send_beat(52'(i), 1'b0, dq(longint'(i), tbl_m[i]));

        // Table write colliding with a transfer at the same index
        fill_until(4);
        send_beat_w(52'sd3, 1'b0, 52'sd3, 1'b1, 6'd4, 3'd1);
        fill_block();
        fill_until(4);
        send_beat(52'sd3, 1'b0, 52'sd6);
        send_beat(52'sd11, 1'b0, dq(11, tbl_m[5]));

        // Reset mid-block with an output pending
        rst = 1'b1;
        q.delete();
        m_pos = 0;
        for (int i = 0; i < 64; i++) tbl_m[i] = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_coeff", out_coeff, 0);
        chk("midrst_out_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_beat(52'sd5, 1'b0, 52'sd5);
        fill_until(4);
        send_beat(52'sd3, 1'b0, 52'sd3);
        send_beat(P50, 1'b0, P50);
        fill_block();

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
